// File: rtl/power_seq_ctrl.sv
// rtl/power_seq_ctrl.sv - camera power-up, reset, configuration and frame-sync sequencer
module power_seq_ctrl #(
    parameter logic [23:0] T_PWDN      = 24'd50000,
    parameter logic [23:0] T_RST       = 24'd50000,
    parameter logic [23:0] T_SETTLE    = 24'd1000000,
    parameter logic [23:0] CFG_TIMEOUT = 24'd5000000,
    parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       delay_done,
    input  logic       cfg_done,
    input  logic       cfg_err,
    input  logic       cam_vsync,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_start,
    output logic       capture_en,
    output logic       seq_fault,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PWDN   = 3'd1,
        S_RST    = 3'd2,
        S_SETTLE = 3'd3,
        S_CFG    = 3'd4,
        S_SYNC   = 3'd5,
        S_RUN    = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [1:0]  retry, retry_nxt;
    logic        vsync_d;
    logic        fail;
    logic        cam_pwdn_nxt, cam_rst_n_nxt, cfg_start_nxt, capture_en_nxt, seq_fault_nxt;

    // State, counters and registered outputs; outputs are precomputed from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 24'd0;
            retry      <= 2'd0;
            vsync_d    <= 1'b0;
            cam_pwdn   <= 1'b1;
            cam_rst_n  <= 1'b0;
            cfg_start  <= 1'b0;
            capture_en <= 1'b0;
            seq_fault  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry      <= retry_nxt;
            vsync_d    <= cam_vsync;
            cam_pwdn   <= cam_pwdn_nxt;
            cam_rst_n  <= cam_rst_n_nxt;
            cfg_start  <= cfg_start_nxt;
            capture_en <= capture_en_nxt;
            seq_fault  <= seq_fault_nxt;
        end
    end

    // Next-state, counter and retry logic; each timed state leaves when its count reaches T-1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 24'd1;
        retry_nxt = retry;
        fail      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = 24'd0;
                if (delay_done) state_nxt = S_PWDN;
            end
            S_PWDN: begin
                if (cnt == T_PWDN - 24'd1) begin
                    state_nxt = S_RST;
                    cnt_nxt   = 24'd0;
                end
            end
            S_RST: begin
                if (cnt == T_RST - 24'd1) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = 24'd0;
                end
            end
            S_SETTLE: begin
                if (cnt == T_SETTLE - 24'd1) begin
                    state_nxt = S_CFG;
                    cnt_nxt   = 24'd0;
                end
            end
            S_CFG: begin
                // An error wins over a simultaneous done; done on the last cycle still succeeds
                if (cfg_err) begin
                    fail = 1'b1;
                end else if (cfg_done) begin
                    state_nxt = S_SYNC;
                    retry_nxt = 2'd0;
                    cnt_nxt   = 24'd0;
                end else if (cnt == CFG_TIMEOUT - 24'd1) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    cnt_nxt = 24'd0;
                    if (retry < MAX_RETRY) begin
                        retry_nxt = retry + 2'd1;
                        state_nxt = S_RST;
                    end else begin
                        state_nxt = S_FAULT;
                    end
                end
            end
            S_SYNC: begin
                cnt_nxt = 24'd0;
                if (vsync_d && !cam_vsync) state_nxt = S_RUN;
            end
            default: begin
                cnt_nxt = 24'd0;
            end
        endcase
    end

    // Output values for the state being entered; cfg_start marks the first cycle of each attempt
    always_comb begin
        cam_pwdn_nxt   = 1'b0;
        cam_rst_n_nxt  = 1'b1;
        capture_en_nxt = 1'b0;
        seq_fault_nxt  = 1'b0;
        cfg_start_nxt  = (state_nxt == S_CFG) && (state != S_CFG);
        case (state_nxt)
            S_IDLE, S_PWDN: begin
                cam_pwdn_nxt  = 1'b1;
                cam_rst_n_nxt = 1'b0;
            end
            S_RST: begin
                cam_rst_n_nxt = 1'b0;
            end
            S_RUN: begin
                capture_en_nxt = 1'b1;
            end
            S_FAULT: begin
                cam_pwdn_nxt  = 1'b1;
                cam_rst_n_nxt = 1'b0;
                seq_fault_nxt = 1'b1;
            end
            default: begin
                cam_pwdn_nxt = 1'b0;
            end
        endcase
    end

    assign seq_state = state;

endmodule
